// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory target for the CPU MEM stage. One access
//            in flight, programmable latency, registered response pulses.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iMemRd,
    input  logic              iMemWr,
    output logic              oReady,
    output logic [DATA_W-1:0] oRdData,
    output logic              oRdValid,
    output logic              oWrAck,
    output logic              oErr
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]        r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [AW-1:0]     r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_op_wr;
    logic              r_fault;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready, w_accept, w_fault_in;
    logic [ADDR_W-1:0] w_addr_hi;
    logic              w_enter_resp, w_commit;
    logic [AW-1:0]     w_c_idx;
    logic [DATA_W-1:0] w_c_wdata;
    logic              w_c_wr, w_c_fault;
    logic              w_rv_nxt, w_wa_nxt, w_err_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;

    assign w_ready    = (r_state != c_WAIT);
    assign w_accept   = (iMemRd | iMemWr) & w_ready;
    assign w_addr_hi  = iAddr >> (AW + 2);
    // Simultaneous rd+wr, misalignment and out-of-range all fault the access.
    assign w_fault_in = (iMemRd & iMemWr) | (|iAddr[1:0]) | (|w_addr_hi);
    assign oReady     = w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_fault <= w_fault_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= iAddr[AW+1:2];
            r_wdata <= iWrData;
            r_op_wr <= iMemWr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == c_WAIT) begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                w_state_nxt = c_RESP;
            end
        end else if (w_accept) begin
            if (LATENCY == 1) begin
                w_state_nxt = c_RESP;
                w_cnt_nxt   = 4'd0;
            end else begin
                w_state_nxt = c_WAIT;
                w_cnt_nxt   = c_CNT_LOAD;
            end
        end else begin
            w_state_nxt = c_IDLE;
        end
    end

    // With LATENCY=1 the response is set up on the acceptance edge itself,
    // so the live request is used instead of the latched copy.
    always_comb begin
        w_enter_resp = ((r_state == c_WAIT) && (r_cnt == 4'd1)) ||
                       ((LATENCY == 1) && w_accept);
        if (r_state == c_WAIT) begin
            w_c_idx   = r_idx;
            w_c_wdata = r_wdata;
            w_c_wr    = r_op_wr;
            w_c_fault = r_fault;
        end else begin
            w_c_idx   = iAddr[AW+1:2];
            w_c_wdata = iWrData;
            w_c_wr    = iMemWr;
            w_c_fault = w_fault_in;
        end
        w_commit    = w_enter_resp & w_c_wr & ~w_c_fault;
        w_rv_nxt    = w_enter_resp & ~w_c_wr;
        w_wa_nxt    = w_enter_resp & w_c_wr;
        w_err_nxt   = w_enter_resp & w_c_fault;
        w_rdata_nxt = (w_rv_nxt && !w_c_fault) ? r_mem[w_c_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oRdValid <= 1'b0;
            oWrAck   <= 1'b0;
            oErr     <= 1'b0;
            oRdData  <= '0;
        end else begin
            oRdValid <= w_rv_nxt;
            oWrAck   <= w_wa_nxt;
            oErr     <= w_err_nxt;
            oRdData  <= w_rdata_nxt;
        end
    end

    // Storage survives reset; a reset edge also suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            r_mem[w_c_idx] <= w_c_wdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that services the load/store port driven by the pipelined CPU's MEM stage. It is the target end of the CPU's data-memory interface: address, write data and read/write strobes. It accepts one request at a time, holds it for a programmable access latency, then commits the write or returns read data with a one-cycle valid pulse. A ready flag lets the MEM stage stall while an access is in flight. Backing store is an internal word array; contents are not cleared by reset.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 32, byte-address width from CPU
- DEPTH, 256, words of storage (power of two); AW = log2(DEPTH)
- LATENCY, 3, cycles from request acceptance to response cycle; legal range 1..15
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- iAddr  input  ADDR_W  byte address
- iWrData  input  DATA_W  store data
- iMemRd  input  1  load request
- iMemWr  input  1  store request
- oReady  output  1  responder can accept a request this cycle
- oRdData  output  DATA_W  load data, valid only while oRdValid=1
- oRdValid  output  1  one-cycle pulse, load data returned
- oWrAck  output  1  one-cycle pulse, store committed
- oErr  output  1  one-cycle pulse in response cycle, request faulted

## Operation
- States: IDLE, WAIT, RESP. Counter cnt, 4 bits.
- Request = iMemRd | iMemWr. Accepted on a rising edge where request=1 and oReady=1. oReady = (state != WAIT).
- On acceptance, latch iAddr, iWrData, op. op = write if iMemWr=1, including when iMemRd=1 at the same time. Rd+Wr together also sets a latched fault flag.
- Fault flag also set if iAddr[1:0] != 0 (misaligned) or iAddr[ADDR_W-1:AW+2] != 0 (out of range).
- Word index = latched iAddr[AW+1:2].
- IDLE or RESP + accept: if LATENCY=1, go to RESP; else go to WAIT with cnt=LATENCY-1.
- IDLE or RESP, no accept: go to IDLE.
- WAIT: cnt decrements each cycle. When cnt=1, go to RESP next edge. Requests presented during WAIT are ignored, not queued.
- Write commit: array written at the edge entering RESP, only if no fault.
- RESP cycle, write: oWrAck=1.
- RESP cycle, read: oRdValid=1, oRdData=mem[index] (registered at entry to RESP). If faulted, oRdData=0.
- oErr=1 in RESP when faulted, alongside oWrAck or oRdValid. A faulted write commits nothing.
- Outputs are registered, except oReady, which decodes the state register.

## Timing
- Reset (synchronous, overrides all):
  - state=IDLE, cnt=0, latched fault cleared.
  - oReady=1, oRdValid=0, oWrAck=0, oErr=0, oRdData=0.
  - Memory array unchanged.
- Reset mid-WAIT: in-flight request dropped, no write commit, no response pulse.
- Latency: request accepted at edge E0 gives the response cycle immediately after edge E0+(LATENCY-1). That is LATENCY cycles of occupancy; oReady=0 for exactly LATENCY-1 cycles.
- Back-to-back: a new request can be accepted in the RESP cycle. Sustained throughput is one access per LATENCY cycles.
- Read after write to the same word, back-to-back: the write commits at RESP entry, so the following read returns the new data.
- Response pulses never last more than one cycle. oRdValid and oWrAck are never high together.

## Test plan
- Reset, then check idle outputs: oReady=1, oRdValid=0, oWrAck=0, oErr=0, oRdData=0.
- LATENCY=3, store iAddr=0x10, iWrData=0xDEADBEEF:
  - oReady=0 for 2 cycles, then oWrAck pulse in the 3rd cycle after acceptance.
  - A following load from 0x10 returns oRdValid with 0xDEADBEEF 3 cycles after its acceptance.
- LATENCY=1, alternate store/load every cycle at 0x20/0x24:
  - oReady stays 1 throughout.
  - Each response arrives the cycle after acceptance; load of 0x20 returns the data just stored.
- Load at 0x13 (misaligned) and at 0x400 with DEPTH=256 (out of range):
  - Each gives oRdValid=1, oErr=1, oRdData=0.
  - Store to 0x400 gives oWrAck=1, oErr=1, and the array is unchanged.
- Assert iMemRd=iMemWr=1 at 0x8 with data 0x5:
  - Treated as a faulted write: oWrAck=1, oErr=1.
  - mem[2] is unchanged.
- Reset for one cycle during WAIT of a store to 0x30 (0x1234):
  - No oWrAck follows.
  - A later load of 0x30 returns the prior contents.
  - oReady=1 in the cycle after reset.
